// File: rtl/evenodd_frame_stats.sv
// Frame statistics for the even/odd detector stream. Counts parities, flag mismatches and
// the longest same-parity run per frame, and hands out one summary per frame.
module evenodd_frame_stats #(
    parameter int WINDOW  = 8,
    parameter int RUN_LEN = 3,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       x,
    input  logic             even,
    input  logic             odd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] even_count,
    output logic [CNT_W-1:0] odd_count,
    output logic [CNT_W-1:0] max_run,
    output logic [CNT_W-1:0] mismatch_count,
    output logic             run_alarm
);

    localparam logic [CNT_W-1:0] WIN_C = CNT_W'(WINDOW);
    localparam logic [CNT_W-1:0] RUN_C = CNT_W'(RUN_LEN);

    typedef enum logic {COLLECT = 1'b0, REPORT = 1'b1} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] smp_cnt_q, even_q, odd_q, mm_q, run_len_q, max_q;
    logic             last_par_q, last_vld_q;
    logic [CNT_W-1:0] even_count_q, odd_count_q, max_run_q, mismatch_count_q;
    logic             run_alarm_q;

    logic             accept, par, flag_bad, same;
    logic [CNT_W-1:0] smp_cnt_d, even_d, odd_d, mm_d, run_len_d, max_d;
    logic             unused_x;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Only x[0] classifies the sample; the flags are merely audited against it.
    assign unused_x = ^x[3:1];
    assign accept   = in_valid && in_ready;
    assign par      = x[0];
    assign flag_bad = (even != ~x[0]) || (odd != x[0]);
    assign same     = last_vld_q && (last_par_q == par);

    always_comb begin
        smp_cnt_d = sat_inc(smp_cnt_q);
        even_d    = par ? even_q : sat_inc(even_q);
        odd_d     = par ? sat_inc(odd_q) : odd_q;
        mm_d      = flag_bad ? sat_inc(mm_q) : mm_q;
        run_len_d = same ? sat_inc(run_len_q) : CNT_W'(1);
        max_d     = (run_len_d > max_q) ? run_len_d : max_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= COLLECT;
            smp_cnt_q        <= '0;
            even_q           <= '0;
            odd_q            <= '0;
            mm_q             <= '0;
            run_len_q        <= '0;
            max_q            <= '0;
            last_par_q       <= 1'b0;
            last_vld_q       <= 1'b0;
            even_count_q     <= '0;
            odd_count_q      <= '0;
            max_run_q        <= '0;
            mismatch_count_q <= '0;
            run_alarm_q      <= 1'b0;
        end else begin
            run_alarm_q <= 1'b0;
            case (state_q)
                COLLECT: begin
                    if (accept) begin
                        smp_cnt_q   <= smp_cnt_d;
                        even_q      <= even_d;
                        odd_q       <= odd_d;
                        mm_q        <= mm_d;
                        run_len_q   <= run_len_d;
                        max_q       <= max_d;
                        last_par_q  <= par;
                        last_vld_q  <= 1'b1;
                        // Guard on the old length so a saturated run cannot re-fire.
                        run_alarm_q <= (run_len_d == RUN_C) && (run_len_q != RUN_C);
                        if (smp_cnt_d == WIN_C) begin
                            state_q          <= REPORT;
                            even_count_q     <= even_d;
                            odd_count_q      <= odd_d;
                            max_run_q        <= max_d;
                            mismatch_count_q <= mm_d;
                        end
                    end
                end
                REPORT: begin
                    if (out_ready) begin
                        state_q    <= COLLECT;
                        smp_cnt_q  <= '0;
                        even_q     <= '0;
                        odd_q      <= '0;
                        mm_q       <= '0;
                        run_len_q  <= '0;
                        max_q      <= '0;
                        last_par_q <= 1'b0;
                        last_vld_q <= 1'b0;
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign in_ready       = (state_q == COLLECT);
    assign out_valid      = (state_q == REPORT);
    assign even_count     = even_count_q;
    assign odd_count      = odd_count_q;
    assign max_run        = max_run_q;
    assign mismatch_count = mismatch_count_q;
    assign run_alarm      = run_alarm_q;

endmodule
